// File: rtl/md_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 encodings,
// FSM states and the fixed results of the special-case paths.
package md_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [31:0] DIV0_Q  = 32'hFFFFFFFF;
    localparam logic [31:0] INT_MIN = 32'h80000000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } md_state_e;

    // rs1 is signed for MUL, MULH, MULHSU, DIV and REM.
    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is signed for MULH, DIV and REM; MULHSU treats it as unsigned.
    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/md_addsub.sv
// 33-bit combinational adder/subtractor; sub inverts y and injects a carry of one.
module md_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         sub_i,
    output logic [W-1:0] s_o
);

    logic [W-1:0] y_eff;

    assign y_eff = sub_i ? ~y_i : y_i;
    assign s_o   = x_i + y_eff + {{(W-1){1'b0}}, sub_i};

endmodule

// File: rtl/md_sequencer.sv
// Iterative RV32M multiply/divide unit: 32 add/subtract steps on operand magnitudes,
// then a sign-fixup cycle, then a one-cycle done pulse with a held result.
module md_sequencer
    import md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    md_state_e       state_q;
    logic [2:0]      op_q;
    logic            sa_q, sb_q;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] hi_q, lo_q, mc_q;
    logic            busy_q, done_q;
    logic [XLEN-1:0] result_q;

    // Accept-side decode of the incoming request.
    logic            sa_d, sb_d;
    logic [XLEN-1:0] ma_d, mb_d;
    logic            div0_d, ovf_d;
    logic [XLEN-1:0] spec_res_d;

    assign sa_d   = a_i[XLEN-1] & a_is_signed(op_i);
    assign sb_d   = b_i[XLEN-1] & b_is_signed(op_i);
    assign ma_d   = sa_d ? -a_i : a_i;
    assign mb_d   = sb_d ? -b_i : b_i;
    assign div0_d = op_i[2] && (b_i == '0);
    assign ovf_d  = ((op_i == MD_DIV) || (op_i == MD_REM)) && (a_i == INT_MIN) && (b_i == '1);
    assign spec_res_d = div0_d ? (op_i[1] ? a_i : DIV0_Q)
                               : (op_i[1] ? '0  : INT_MIN);

    // Multiply adds the multiplicand into the high half; divide trial-subtracts
    // the divisor from the remainder shifted left by the next dividend bit.
    logic [XLEN:0] as_x, as_y, as_s;

    assign as_x = op_q[2] ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
    assign as_y = {1'b0, mc_q};

    md_addsub #(.W(XLEN+1)) u_addsub (
        .x_i   (as_x),
        .y_i   (as_y),
        .sub_i (op_q[2]),
        .s_o   (as_s)
    );

    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] step_hi_d, step_lo_d;

    always_comb begin
        mul_sum   = '0;
        step_hi_d = hi_q;
        step_lo_d = lo_q;
        if (op_q[2]) begin
            step_hi_d = as_s[XLEN] ? as_x[XLEN-1:0] : as_s[XLEN-1:0];
            step_lo_d = {lo_q[XLEN-2:0], ~as_s[XLEN]};
        end else begin
            mul_sum   = lo_q[0] ? as_s : as_x;
            step_hi_d = mul_sum[XLEN:1];
            step_lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res_d;

    assign prod     = {hi_q, lo_q};
    assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;
    assign quo_fix  = (sa_q ^ sb_q) ? -lo_q : lo_q;
    assign rem_fix  = sa_q ? -hi_q : hi_q;
    assign fix_res_d = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                               : ((op_q == MD_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mc_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        op_q   <= op_i;
                        sa_q   <= sa_d;
                        sb_q   <= sb_d;
                        cnt_q  <= '0;
                        hi_q   <= '0;
                        lo_q   <= op_i[2] ? ma_d : mb_d;
                        mc_q   <= op_i[2] ? mb_d : ma_d;
                        busy_q <= 1'b1;
                        if (div0_d || ovf_d) begin
                            result_q <= spec_res_d;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    hi_q  <= step_hi_d;
                    lo_q  <= step_lo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q <= fix_res_d;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed RV32M vectors, randomized ops against
// an arithmetic reference model, special cases, ignored starts and mid-run reset.
module tb_md_sequencer;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    md_sequencer #(.XLEN(32)) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .start_i  (start),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics from plain 64-bit / native integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        int          ix, iy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        ix = $signed(x);
        iy = $signed(y);
        case (o)
            3'd0: begin p = 64'(ux * uy); return p[31:0];  end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = 64'(ux * uy); return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ix / iy);
            end
            3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                return 32'(ix % iy);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && y == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
        return 34;
    endfunction

    // Drives one request from a negedge; returns result, cycles to done (-1 on timeout),
    // count of accept..done cycles without busy, and whether the cycle after done was idle
    // with result held. poke>0 pulses a stray start with junk operands in that cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int poke, output logic [31:0] res, output int lat,
                          output int busy_bad, output bit after_ok);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = -1; busy_bad = 0; res = 'x;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == poke) begin
                start = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                lat = n; res = result;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        after_ok = (busy === 1'b0) && (done === 1'b0) && (result === res);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b result=%h want 0/0/0", busy, done, result);
        end
        reset = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] x, y, exp;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[16];
        logic [31:0] res;
        int lat, bb;
        bit aok;
        v[0]  = '{3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        v[1]  = '{3'd1, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 34};
        v[2]  = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        v[3]  = '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 34};
        v[4]  = '{3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 34};
        v[5]  = '{3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 34};
        v[6]  = '{3'd5, 32'd100,       32'd7,        32'd14,       34};
        v[7]  = '{3'd7, 32'd100,       32'd7,        32'd2,        34};
        v[8]  = '{3'd4, 32'h12345678,  32'd0,        32'hFFFFFFFF, 1};
        v[9]  = '{3'd5, 32'h12345678,  32'd0,        32'hFFFFFFFF, 1};
        v[10] = '{3'd6, 32'h12345678,  32'd0,        32'h12345678, 1};
        v[11] = '{3'd7, 32'h12345678,  32'd0,        32'h12345678, 1};
        v[12] = '{3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
        v[13] = '{3'd6, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1};
        v[14] = '{3'd1, 32'h80000000,  32'h80000000, 32'h40000000, 34};
        v[15] = '{3'd6, 32'd7,         32'hFFFFFFFE, 32'd1,        34};
        foreach (v[i]) begin
            run_op(v[i].o, v[i].x, v[i].y, 0, res, lat, bb, aok);
            checks++;
            if (res !== v[i].exp || lat != v[i].lat || bb != 0 || !aok) begin
                errors++;
                $display("FAIL directed_%0d op=%0d a=%h b=%h got res=%h lat=%0d busy_gaps=%0d idle_after=%0b want res=%h lat=%0d 0 1",
                         i, v[i].o, v[i].x, v[i].y, res, lat, bb, aok, v[i].exp, v[i].lat);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y, res, exp;
        logic [2:0]  o;
        int lat, bb;
        bit aok;
        for (int i = 0; i < 50; i++) begin
            o = 3'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: x = 32'h80000000;
                3: y = 32'($urandom_range(1, 15));
                default: ;
            endcase
            exp = model(o, x, y);
            run_op(o, x, y, 0, res, lat, bb, aok);
            checks++;
            if (res !== exp || lat != model_lat(o, x, y) || bb != 0 || !aok) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h got res=%h lat=%0d busy_gaps=%0d idle_after=%0b want res=%h lat=%0d",
                         i, o, x, y, res, lat, bb, aok, exp, model_lat(o, x, y));
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] res;
        int lat, bb, extra;
        bit aok;
        run_op(3'd4, 32'hDEADBEEF, 32'h00001234, 15, res, lat, bb, aok);
        extra = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (res !== model(3'd4, 32'hDEADBEEF, 32'h00001234) || lat != 34 || !aok || extra != 0) begin
            errors++;
            $display("FAIL start_mid_run got res=%h lat=%0d idle_after=%0b extra_busy=%0d want res=%h lat=34 1 0",
                     res, lat, aok, extra, model(3'd4, 32'hDEADBEEF, 32'h00001234));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat, bb;
        bit aok;
        // Stray start in the DONE cycle must not be accepted.
        run_op(3'd3, 32'hCAFEF00D, 32'h0BADBEEF, 34, res, lat, bb, aok);
        checks++;
        if (res !== model(3'd3, 32'hCAFEF00D, 32'h0BADBEEF) || lat != 34 || !aok) begin
            errors++;
            $display("FAIL b2b_done_start got res=%h lat=%0d idle_after=%0b want res=%h lat=34 1",
                     res, lat, aok, model(3'd3, 32'hCAFEF00D, 32'h0BADBEEF));
        end
        // Re-accept in the first IDLE cycle after DONE.
        run_op(3'd7, 32'h00000123, 32'h0, 1, res, lat, bb, aok);
        checks++;
        if (res !== 32'h00000123 || lat != 1 || !aok) begin
            errors++;
            $display("FAIL b2b_special got res=%h lat=%0d idle_after=%0b want res=00000123 lat=1 1", res, lat, aok);
        end
        run_op(3'd0, 32'h00010001, 32'h00010001, 0, res, lat, bb, aok);
        checks++;
        if (res !== 32'h00020001 || lat != 34 || bb != 0 || !aok) begin
            errors++;
            $display("FAIL b2b_normal got res=%h lat=%0d busy_gaps=%0d idle_after=%0b want res=00020001 lat=34 0 1",
                     res, lat, bb, aok);
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        checks++;
        if (result === 32'h0) begin
            errors++;
            $display("FAIL reset_mid_precond result=%h want nonzero", result);
        end
        start = 1'b1; op = 3'd5; a = 32'hFFFF0000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b result=%h want 0/0/0", busy, done, result);
        end
        extra = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_discard extra_busy=%0d result=%h want 0 00000000", extra, result);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
